// File: rtl/serial_word_assembler_pkg.sv
// rtl/serial_word_assembler_pkg.sv - shared types and defaults for the serial word assembler
package serial_word_assembler_pkg;

  // Handshake FSM encodings: COLLECT accepts bits, STALL holds the last partial bit
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STALL   = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH     = 8;
  localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_assembler_dff_en.sv
// rtl/serial_word_assembler_dff_en.sv - width-parameterised enable register with synchronous reset
module serial_word_assembler_dff_en #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Load d when enabled; reset clears to zero
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_word_assembler.sv
// rtl/serial_word_assembler.sv - single-bit stream deserializer with double-buffered word output
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = DEFAULT_MSB_FIRST,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_word_valid;
  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] w_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [WIDTH-1:0] w_shreg_d;
  logic             w_shreg_en;

  logic w_ready;
  logic w_accept;
  logic w_shift;
  logic w_last;
  logic w_complete;
  logic w_take;
  logic w_stall_cond;

  // Handshake qualifiers; clear overrides any accept in the same cycle
  assign w_last       = (r_count == LAST_COUNT);
  assign w_accept     = bit_valid & w_ready;
  assign w_shift      = w_accept & ~clear;
  assign w_complete   = w_shift & w_last;
  assign w_take       = r_word_valid & word_ready;
  assign w_stall_cond = w_last & r_word_valid & ~word_ready;

  // Next shift-register value for the configured bit order
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shreg_next = {w_shreg[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign w_shreg_next = {bit_in, w_shreg[WIDTH-1:1]};
    end
  endgenerate

  // Shift register only moves on a real accept, so bit_in is ignored while bit_valid is low
  assign w_shreg_en = w_shift | clear;
  assign w_shreg_d  = clear ? '0 : w_shreg_next;

  serial_word_assembler_dff_en #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clock(clock),
    .reset(reset),
    .en   (w_shreg_en),
    .d    (w_shreg_d),
    .q    (w_shreg)
  );

  // Output word loads the full word (partial plus completing bit) on the completing edge
  serial_word_assembler_dff_en #(
    .WIDTH(WIDTH)
  ) u_word (
    .clock(clock),
    .reset(reset),
    .en   (w_complete),
    .d    (w_shreg_next),
    .q    (word_out)
  );

  // Bit counter: wraps on the completing bit, zeroed by clear
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (w_shift) begin
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

  // word_valid: a new word wins over a simultaneous take so there is no bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_valid <= 1'b0;
    end else if (w_complete) begin
      r_word_valid <= 1'b1;
    end else if (w_take) begin
      r_word_valid <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and bit_ready; in STALL the output is full, so only a take frees it
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b1;
    case (r_state)
      ST_COLLECT: begin
        w_ready = ~w_stall_cond;
        if (!clear && w_stall_cond && !w_accept) begin
          w_state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        w_ready = word_ready;
        if (clear || w_take) begin
          w_state_next = ST_COLLECT;
        end
      end
      default: begin
        w_state_next = ST_COLLECT;
      end
    endcase
  end

  assign bit_ready  = w_ready;
  assign word_valid = r_word_valid;
  assign bit_count  = r_count;

endmodule
